insn_encoder: RTL
=================

# insn_encoder

Streaming RV32I instruction encoder and instruction-memory writer: the inverse of the decode/control path. It accepts instruction descriptors (instruction class, ALU select, register indices, immediate) over a valid/ready handshake, buffers them in a small FIFO, and packs each into a 32-bit instruction word. It then writes the words to consecutive instruction-memory addresses through a valid/ready write port. It sits between the bench/boot sequencer and the imem write port, and uses the same opcode, ALU-select and writeback constants as the decode stage.

## Interface
- DWIDTH, 32, instruction/data width
- AWIDTH, 32, write-address width
- BASE_ADDR, 32'h0100_0000, first write address after start_i
- DEPTH, 4, descriptor FIFO entries (power of 2, ≥2)

- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset
- start_i  input  1  begin a program load (honoured only in IDLE)
- op_valid_i  input  1  descriptor valid
- op_ready_o  output  1  descriptor accepted when valid&ready at an edge
- op_kind_i  input  4  0 RTYPE, 1 ITYPE, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC
- alusel_i  input  4  ALU code (ADD, SUB, SLL, …); used by RTYPE/ITYPE only
- funct3_i  input  3  width/condition; used by LOAD/STORE/BRANCH only
- rd_i, rs1_i, rs2_i  input  5 each  register indices
- imm_i  input  DWIDTH  immediate as a full signed value / byte offset
- last_i  input  1  descriptor is the final one of the program
- wr_valid_o  output  1  write request
- wr_ready_i  input  1  memory accepts the write
- wr_addr_o  output  AWIDTH  write address
- wr_data_o  output  DWIDTH  encoded instruction
- done_o  output  1  one-cycle pulse when the load completes
- err_o  output  1  sticky: an illegal descriptor was seen since start

## Operation
- FSM: IDLE, RUN, FLUSH.
  - IDLE → RUN on start_i: addr := BASE_ADDR; err_o := 0.
  - RUN → FLUSH on acceptance of a descriptor with last_i=1.
  - FLUSH → IDLE when the FIFO is empty and the output register is empty. done_o pulses in the cycle after that transition edge.
- op_ready_o = (state==RUN) & FIFO not full. No acceptance in IDLE/FLUSH. start_i is ignored outside IDLE.
- Encode stage: when the output register is empty, or is being emptied this cycle, pop the FIFO head, encode it, and load it into the output register.
- Encoding (standard RV32I field placement):
  - RTYPE: funct3/funct7 from alusel_i (SUB, SRA → funct7 0x20).
  - ITYPE: funct3 from alusel_i. SLL/SRL/SRA use shamt = imm_i[4:0], with funct7 0x20 for SRA.
  - LOAD/JALR: I-format; JALR funct3 = 0.
  - STORE: S-format.
  - BRANCH: B-format; imm_i[0] ignored.
  - JAL: J-format; imm_i[0] ignored.
  - LUI/AUIPC: imm_i[31:12] used, imm_i[11:0] ignored.
  - Unused fields are zero.
- Illegal descriptors: op_kind_i > 8; SUB or PCADD with ITYPE; PCADD with RTYPE; funct3 invalid for LOAD (3, 6, 7), STORE (≥3) or BRANCH (2, 3).
  - Illegal descriptors encode as 32'h0000_0013 (addi x0,x0,0).
  - They still consume an address.
  - They set err_o, which holds until the next start_i.
- Address: increments by 4 on each wr_valid_o&wr_ready_i. It wraps modulo 2^AWIDTH with no error.

## Timing
- Reset values:
  - State: IDLE.
  - FIFO: empty. Output register: empty.
  - Outputs: op_ready_o=0, wr_valid_o=0, wr_addr_o=BASE_ADDR, wr_data_o=0, done_o=0, err_o=0.
- Latency: a descriptor accepted at edge E into an empty FIFO with an empty output register is presented with wr_valid_o=1 after edge E+1.
- Throughput: 1 word/cycle sustained while wr_ready_i=1.
- Handshake rules:
  - wr_valid_o, wr_addr_o and wr_data_o stay stable while wr_valid_o & !wr_ready_i.
  - No FIFO pop occurs while the output register is stalled.
- FIFO full with a pop in the same cycle: op_ready_o stays 0 that cycle, so the decision is registered-safe with no combinational path from wr_ready_i.
- FIFO empty: wr_valid_o deasserts after the last handshake.
- Simultaneous events: the last_i acceptance and a write handshake in the same cycle are both honoured.
- Reset asserted mid-operation: the FIFO and output register are discarded, no done_o is produced, and all outputs return to their reset values at the next edge.

## Test plan
- Reset, start_i, then RTYPE ADD rd=3 rs1=1 rs2=2 → wr_data_o=32'h002081B3 at 32'h0100_0000; wr_valid_o rises after edge E+1.
- ITYPE ADD rd=1 rs1=0 imm=5, then ITYPE SRA rd=1 rs1=1 imm=3 → 32'h00500093, then 32'h4030D093 at addresses 0x0100_0000 and 0x0100_0004.
- STORE funct3=2 rs1=1 rs2=2 imm=8 → 32'h0020A423. LUI rd=5 imm=32'h1234_5000 → 32'h123452B7. JAL rd=1 imm=8 with last_i=1 → 32'h008000EF; done_o pulses once after the final handshake.
- Hold wr_ready_i=0 for 10 cycles while 6 descriptors are offered → op_ready_o drops after DEPTH+1 are held; outputs stay stable; releasing wr_ready_i drains all 6 in order with no loss or duplication.
- op_kind_i=12 → 32'h00000013 written, address advances, err_o=1 and stays 1 until the next start_i.
- Reset asserted with 3 descriptors pending → at the next edge: wr_valid_o=0, FIFO empty, state IDLE, no done_o. A following start_i restarts at BASE_ADDR.

Source files
------------

// File: rtl/insn_encoder_if.sv
// Descriptor input channel and instruction-memory write channel of insn_encoder.
// Ports: op_* (descriptor, valid/ready), wr_* (address/data write, valid/ready).
// The slave modport is the encoder's view; master is the sequencer/memory side.
interface insn_encoder_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    // descriptor channel
    logic              op_valid;
    logic              op_ready;
    logic [3:0]        op_kind;
    logic [3:0]        alusel;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [DWIDTH-1:0] imm;
    logic              last;

    // instruction-memory write channel
    logic              wr_valid;
    logic              wr_ready;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;

    modport master (
        output op_valid, op_kind, alusel, funct3, rd, rs1, rs2, imm, last,
        output wr_ready,
        input  op_ready,
        input  wr_valid, wr_addr, wr_data
    );

    modport slave (
        input  op_valid, op_kind, alusel, funct3, rd, rs1, rs2, imm, last,
        input  wr_ready,
        output op_ready,
        output wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/insn_encoder.sv
// Packs RV32I instruction descriptors into 32-bit words and writes them to consecutive imem addresses.
// Latency: descriptor accepted at edge E (idle pipe) is presented on the write port after edge E+1.
// Backpressure: a stalled write holds the output register and FIFO; op_ready drops once DEPTH+1 are held.
//
// Ports:
//   clk, reset (sync, active-low), start_i  - clock, reset, program-load start (IDLE only)
//   bus (slave)  - op_* descriptor channel in, wr_* write channel out
//   done_o       - one-cycle pulse after the load has fully drained
//   err_o        - sticky illegal-descriptor flag, cleared by start_i
module insn_encoder #(
    parameter int                DWIDTH    = 32,
    parameter int                AWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0100_0000),
    parameter int                DEPTH     = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    insn_encoder_if.slave bus,
    output logic          done_o,
    output logic          err_o
);

    // descriptor kinds
    localparam logic [3:0] K_RTYPE  = 4'd0;
    localparam logic [3:0] K_ITYPE  = 4'd1;
    localparam logic [3:0] K_LOAD   = 4'd2;
    localparam logic [3:0] K_STORE  = 4'd3;
    localparam logic [3:0] K_BRANCH = 4'd4;
    localparam logic [3:0] K_JAL    = 4'd5;
    localparam logic [3:0] K_JALR   = 4'd6;
    localparam logic [3:0] K_LUI    = 4'd7;
    localparam logic [3:0] K_AUIPC  = 4'd8;

    // ALU select codes shared with the decode stage
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    // 4'd10 is PCADD (auipc datapath); it has no R/I encoding, so it falls
    // into the "not encodable" default together with undefined codes.

    // major opcodes
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;   // addi x0,x0,0

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]        kind;
        logic [3:0]        alusel;
        logic [2:0]        funct3;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [DWIDTH-1:0] imm;
    } desc_t;

    state_t            state, state_nxt;
    logic              start_go;
    logic              done_nxt;

    desc_t             fifo_mem [DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [PW:0]       count;
    logic              fifo_full, fifo_empty;
    logic              push, pop;

    logic              out_vld;
    logic [DWIDTH-1:0] out_dat;
    logic [AWIDTH-1:0] addr;
    logic              err_q;
    logic              done_q;
    logic              wr_fire;

    desc_t             head;
    logic [31:0]       imm32;
    logic [2:0]        alu_f3;
    logic [6:0]        alu_f7;
    logic              alu_ok;
    logic              alu_shift;
    logic [31:0]       enc_word;
    logic              enc_ill;

    // ---------------------------------------------------------------
    // Handshakes. op_ready depends only on registered state, never on
    // wr_ready, so a full FIFO refuses input even in a cycle it pops.
    // ---------------------------------------------------------------
    assign fifo_full  = (count == (PW+1)'(DEPTH));
    assign fifo_empty = (count == '0);

    assign bus.op_ready = (state == ST_RUN) && !fifo_full;
    assign push         = bus.op_valid && bus.op_ready;
    assign wr_fire      = out_vld && bus.wr_ready;
    // refill the output register whenever it is empty or draining this cycle
    assign pop          = !fifo_empty && (!out_vld || bus.wr_ready);

    assign bus.wr_valid = out_vld;
    assign bus.wr_addr  = addr;
    assign bus.wr_data  = out_dat;
    assign done_o       = done_q;
    assign err_o        = err_q;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_RUN;
                    start_go  = 1'b1;
                end
            end
            ST_RUN: begin
                if (push && bus.last) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fifo_empty && !out_vld) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // ALU select -> funct3/funct7
    // ---------------------------------------------------------------
    always_comb begin
        alu_f3    = 3'b000;
        alu_f7    = 7'h00;
        alu_ok    = 1'b1;
        alu_shift = 1'b0;
        case (head.alusel)
            ALU_ADD:  alu_f3 = 3'b000;
            ALU_SUB:  begin alu_f3 = 3'b000; alu_f7 = 7'h20; end
            ALU_SLL:  begin alu_f3 = 3'b001; alu_shift = 1'b1; end
            ALU_SLT:  alu_f3 = 3'b010;
            ALU_SLTU: alu_f3 = 3'b011;
            ALU_XOR:  alu_f3 = 3'b100;
            ALU_SRL:  begin alu_f3 = 3'b101; alu_shift = 1'b1; end
            ALU_SRA:  begin alu_f3 = 3'b101; alu_f7 = 7'h20; alu_shift = 1'b1; end
            ALU_OR:   alu_f3 = 3'b110;
            ALU_AND:  alu_f3 = 3'b111;
            default:  alu_ok = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------
    // Encoder on the FIFO head
    // ---------------------------------------------------------------
    always_comb begin
        head     = fifo_mem[rptr];
        imm32    = head.imm[31:0];
        enc_word = NOP_WORD;
        enc_ill  = 1'b0;
        case (head.kind)
            K_RTYPE: begin
                if (!alu_ok) enc_ill = 1'b1;
                else enc_word = {alu_f7, head.rs2, head.rs1, alu_f3, head.rd, OP_RTYPE};
            end
            K_ITYPE: begin
                if (!alu_ok || head.alusel == ALU_SUB) enc_ill = 1'b1;
                else if (alu_shift)
                    enc_word = {alu_f7, imm32[4:0], head.rs1, alu_f3, head.rd, OP_ITYPE};
                else
                    enc_word = {imm32[11:0], head.rs1, alu_f3, head.rd, OP_ITYPE};
            end
            K_LOAD: begin
                if (head.funct3 inside {3'd3, 3'd6, 3'd7}) enc_ill = 1'b1;
                else enc_word = {imm32[11:0], head.rs1, head.funct3, head.rd, OP_LOAD};
            end
            K_STORE: begin
                if (head.funct3 >= 3'd3) enc_ill = 1'b1;
                else enc_word = {imm32[11:5], head.rs2, head.rs1, head.funct3,
                                 imm32[4:0], OP_STORE};
            end
            K_BRANCH: begin
                if (head.funct3 inside {3'd2, 3'd3}) enc_ill = 1'b1;
                else enc_word = {imm32[12], imm32[10:5], head.rs2, head.rs1, head.funct3,
                                 imm32[4:1], imm32[11], OP_BRANCH};
            end
            K_JAL:   enc_word = {imm32[20], imm32[10:1], imm32[11], imm32[19:12],
                                 head.rd, OP_JAL};
            K_JALR:  enc_word = {imm32[11:0], head.rs1, 3'b000, head.rd, OP_JALR};
            K_LUI:   enc_word = {imm32[31:12], head.rd, OP_LUI};
            K_AUIPC: enc_word = {imm32[31:12], head.rd, OP_AUIPC};
            default: enc_ill  = 1'b1;
        endcase
        if (enc_ill) enc_word = NOP_WORD;
    end

    // ---------------------------------------------------------------
    // FIFO storage: contents need no reset, the pointers define validity
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr] <= '{kind:   bus.op_kind,
                                alusel: bus.alusel,
                                funct3: bus.funct3,
                                rd:     bus.rd,
                                rs1:    bus.rs1,
                                rs2:    bus.rs2,
                                imm:    bus.imm};
        end
    end

    // ---------------------------------------------------------------
    // Control state, FIFO pointers, output register, address, flags
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            out_vld <= 1'b0;
            out_dat <= '0;
            addr    <= BASE_ADDR;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;

            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase

            if (pop) begin
                out_vld <= 1'b1;
                out_dat <= DWIDTH'(enc_word);
                if (enc_ill) err_q <= 1'b1;
            end else if (wr_fire) begin
                out_vld <= 1'b0;
            end

            // start only happens in IDLE with an empty pipe, so it never
            // collides with a write or an illegal pop
            if (start_go) begin
                addr  <= BASE_ADDR;
                err_q <= 1'b0;
            end else if (wr_fire) begin
                addr <= addr + AWIDTH'(4);
            end
        end
    end

endmodule
